bus_rr_arbiter: RTL and testbench
=================================

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 8'd255, max cycles to wait for s_ready before forced error completion (1..255).
REQ-002 clk  in  1  clock; all logic on posedge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 m0_req  in  1  instruction-fetch request, level.
REQ-005 m0_addr  in  64  fetch address.
REQ-006 m0_size  in  3  fetch size code.
REQ-007 m0_gnt  out  1  one-cycle pulse, m0 request accepted.
REQ-008 m0_rvalid  out  1  one-cycle pulse, m0 response valid.
REQ-009 m1_req  in  1  load/store request, level.
REQ-010 m1_wen  in  1  1 = write.
REQ-011 m1_addr  in  64  load/store address.
REQ-012 m1_size  in  3  load/store size code.
REQ-013 m1_wdata  in  64  write data.
REQ-014 m1_wmask  in  8  write byte mask.
REQ-015 m1_gnt  out  1  one-cycle pulse, m1 request accepted.
REQ-016 m1_rvalid  out  1  one-cycle pulse, m1 response valid.
REQ-017 rsp_rdata  out  64  response data shared by both masters; meaningful only with an rvalid.
REQ-018 rsp_err  out  1  response was a timeout; meaningful only with an rvalid.
REQ-019 s_cen, s_wen  out  1 each  downstream RAM enable / write.
REQ-020 s_addr  out  64, s_wdata  out  64, s_wmask  out  8, s_size  out  3  downstream command.
REQ-021 s_ready  in  1, s_rdata  in  64  downstream completion pulse and read data.

Function
REQ-022 States: IDLE, BUSY_M0, BUSY_M1. All outputs registered.
REQ-023 Arbitration happens only in IDLE; requests seen while busy are not accepted.
REQ-024 Priority is round-robin via a last_winner bit (reset = m1), applied as follows:
- only one req high -> that master wins;
- both high -> the master that is not last_winner wins;
- last_winner updates on every grant.
REQ-025 Grant at edge E (IDLE, req high), effective from E:
- state -> BUSY_Mx;
- gnt pulses in the next cycle;
- s_cen = 1;
- command fields latched from the winner.
REQ-026 Command fields for m0: s_wen = 0, s_wdata = 0, s_wmask = 0.
REQ-027 s_cen and all s_* fields hold stable throughout BUSY; s_ready may arrive in the first BUSY cycle.
REQ-028 s_ready sampled high in BUSY at edge F:
- state -> IDLE and s_cen -> 0 (s_* fields -> 0);
- the owner's rvalid pulses in the next cycle;
- rsp_rdata = s_rdata sampled at F;
- rsp_err = 0.
REQ-029 s_ready while IDLE is ignored; it produces no response.
REQ-030 Watchdog: an 8-bit counter clears on grant and increments each BUSY cycle without s_ready.
REQ-031 Watchdog expiry: if the counter reaches TIMEOUT with no s_ready, completion proceeds as REQ-028 with rsp_rdata = 0 and rsp_err = 1.
REQ-032 If s_ready and timeout coincide, s_ready wins (rsp_err = 0).
REQ-033 Back-to-back: in the rvalid cycle the state is already IDLE, so a new grant may be made at that cycle's edge; minimum 3 cycles per transaction.
REQ-034 A master deasserts req, or presents its next request, after sampling its gnt; a req still high in IDLE is treated as a new request.
REQ-035 At most one gnt and at most one rvalid are high in any cycle.

Reset
REQ-036 On rst_n low at an edge:
- state = IDLE, last_winner = m1, watchdog = 0;
- all outputs = 0;
- any in-flight transaction is dropped with no rvalid.
REQ-037 The first grant is possible at the first edge with rst_n high.

Verification
REQ-038 Reset then m0_req alone, addr 0x8000_0000, s_ready 2 cycles after s_cen, s_rdata 0x1234:
- m0_gnt next cycle;
- s_cen high 2 cycles;
- m0_rvalid with rsp_rdata 0x1234, rsp_err 0.
REQ-039 m0_req and m1_req both held continuously, s_ready always 1 cycle after s_cen: grant order m0, m1, m0, m1; never two gnts together.
REQ-040 m1 write, wen 1, wmask 0xF0, wdata 0xAABB: s_wen 1, s_wmask 0xF0, s_wdata 0xAABB stable until s_ready; then m1_rvalid.
REQ-041 s_ready never arrives, TIMEOUT = 4: exactly 4 BUSY cycles, then rvalid with rsp_err 1 and rsp_rdata 0.
REQ-042 rst_n low during BUSY_M1: s_cen 0 the next cycle, no m1_rvalid, first grant after release goes to m0.
REQ-043 s_ready pulses while IDLE with no requests: no rvalid, no state change.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// Two-master round-robin arbiter in front of a single-outstanding RAM port.
// m0 (fetch) and m1 (load/store) share one command path, guarded by a response watchdog.
module bus_rr_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic [63:0] m0_addr,
  input  logic [2:0]  m0_size,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  input  logic        m1_req,
  input  logic        m1_wen,
  input  logic [63:0] m1_addr,
  input  logic [2:0]  m1_size,
  input  logic [63:0] m1_wdata,
  input  logic [7:0]  m1_wmask,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        s_cen,
  output logic        s_wen,
  output logic [63:0] s_addr,
  output logic [63:0] s_wdata,
  output logic [7:0]  s_wmask,
  output logic [2:0]  s_size,
  input  logic        s_ready,
  input  logic [63:0] s_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_M0, BUSY_M1} state_e;

  state_e      state_q;
  logic        last_m1_q;  // 1 = m1 won the most recent grant
  logic [7:0]  wdog_q;
  logic        m0_gnt_q, m1_gnt_q, m0_rvalid_q, m1_rvalid_q;
  logic [63:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic        s_cen_q, s_wen_q;
  logic [63:0] s_addr_q, s_wdata_q;
  logic [7:0]  s_wmask_q;
  logic [2:0]  s_size_q;

  logic        pick_m1;
  logic [7:0]  wdog_inc;

  always_comb begin
    pick_m1  = m1_req & (~m0_req | ~last_m1_q);
    wdog_inc = wdog_q + 8'd1;
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_m1_q   <= 1'b1;
      wdog_q      <= '0;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      s_cen_q     <= 1'b0;
      s_wen_q     <= 1'b0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      s_wmask_q   <= '0;
      s_size_q    <= '0;
    end else begin
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (m0_req || m1_req) begin
            wdog_q    <= '0;
            s_cen_q   <= 1'b1;
            last_m1_q <= pick_m1;
            if (pick_m1) begin
              state_q   <= BUSY_M1;
              m1_gnt_q  <= 1'b1;
              s_wen_q   <= m1_wen;
              s_addr_q  <= m1_addr;
              s_size_q  <= m1_size;
              s_wdata_q <= m1_wdata;
              s_wmask_q <= m1_wmask;
            end else begin
              state_q   <= BUSY_M0;
              m0_gnt_q  <= 1'b1;
              s_wen_q   <= 1'b0;
              s_addr_q  <= m0_addr;
              s_size_q  <= m0_size;
              s_wdata_q <= '0;
              s_wmask_q <= '0;
            end
          end
        end
        BUSY_M0, BUSY_M1: begin
          // A real completion beats a watchdog expiry landing on the same edge.
          if (s_ready || (wdog_inc == TIMEOUT)) begin
            state_q     <= IDLE;
            m0_rvalid_q <= (state_q == BUSY_M0);
            m1_rvalid_q <= (state_q == BUSY_M1);
            rsp_rdata_q <= s_ready ? s_rdata : '0;
            rsp_err_q   <= ~s_ready;
            s_cen_q     <= 1'b0;
            s_wen_q     <= 1'b0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            s_wmask_q   <= '0;
            s_size_q    <= '0;
          end else begin
            wdog_q <= wdog_inc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_gnt    = m0_gnt_q;
  assign m1_gnt    = m1_gnt_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign s_cen     = s_cen_q;
  assign s_wen     = s_wen_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign s_wmask   = s_wmask_q;
  assign s_size    = s_size_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Randomized scoreboard bench for bus_rr_arbiter: a transaction-level model queues expected
// grant/response pulses, and a negedge monitor pops and compares them against the DUT.
module tb_bus_rr_arbiter;

  localparam logic [7:0] TO    = 8'd4;
  localparam int         N_CYC = 4000;

  logic        clk, rst_n;
  logic        m0_req, m0_gnt, m0_rvalid;
  logic [63:0] m0_addr;
  logic [2:0]  m0_size;
  logic        m1_req, m1_wen, m1_gnt, m1_rvalid;
  logic [63:0] m1_addr, m1_wdata;
  logic [2:0]  m1_size;
  logic [7:0]  m1_wmask;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        s_cen, s_wen;
  logic [63:0] s_addr, s_wdata;
  logic [7:0]  s_wmask;
  logic [2:0]  s_size;
  logic        s_ready;
  logic [63:0] s_rdata;

  bus_rr_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_size(m0_size),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_size(m1_size),
    .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .s_cen(s_cen), .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wmask(s_wmask), .s_size(s_size),
    .s_ready(s_ready), .s_rdata(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output pulse: kind 0 = grant, 1 = response; cyc = edge index that produced it.
  typedef struct {
    bit          is_rsp;
    bit          m1;
    int          cyc;
    logic [63:0] rdata;
    bit          err;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0, n_err = 0, cyc = 0;
  int  n_timeout = 0, n_grant = 0;

  // Reference model state: bus ownership, round-robin memory and the expected command.
  bit          m_busy = 1'b0, m_owner = 1'b0, m_last = 1'b1;
  int          m_busy_cycles = 0;
  bit          e_cen = 1'b0, e_wen = 1'b0;
  logic [63:0] e_addr = '0, e_wdata = '0;
  logic [7:0]  e_wmask = '0;
  logic [2:0]  e_size = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_cmd();
    e_cen = 1'b0; e_wen = 1'b0; e_addr = '0; e_wdata = '0; e_wmask = '0; e_size = '0;
  endtask

  // One clock edge of the arbiter's rules, evaluated on the inputs the DUT samples.
  task automatic model_step();
    ev_t ev;
    bit  w;
    cyc++;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_last = 1'b1;
      clear_cmd();
      return;
    end
    if (!m_busy) begin
      if (m0_req || m1_req) begin
        w = (m0_req && m1_req) ? !m_last : m1_req;
        m_busy = 1'b1; m_owner = w; m_last = w; m_busy_cycles = 0;
        e_cen = 1'b1;
        if (w) begin
          e_wen = m1_wen; e_addr = m1_addr; e_size = m1_size;
          e_wdata = m1_wdata; e_wmask = m1_wmask;
        end else begin
          e_wen = 1'b0; e_addr = m0_addr; e_size = m0_size;
          e_wdata = '0; e_wmask = '0;
        end
        ev.is_rsp = 1'b0; ev.m1 = w; ev.cyc = cyc; ev.rdata = '0; ev.err = 1'b0;
        exp_q.push_back(ev);
        n_grant++;
      end
    end else begin
      m_busy_cycles++;
      if (s_ready || (m_busy_cycles == int'(TO))) begin
        ev.is_rsp = 1'b1; ev.m1 = m_owner; ev.cyc = cyc;
        ev.rdata  = s_ready ? s_rdata : 64'd0;
        ev.err    = !s_ready;
        if (!s_ready) n_timeout++;
        exp_q.push_back(ev);
        m_busy = 1'b0;
        clear_cmd();
      end
    end
  endtask

  task automatic monitor_step();
    ev_t        ev;
    logic [3:0] p;
    check("s_cen", s_cen, e_cen);
    check("s_wen", s_wen, e_wen);
    check("s_addr", s_addr, e_addr);
    check("s_wdata", s_wdata, e_wdata);
    check("s_wmask", s_wmask, e_wmask);
    check("s_size", s_size, e_size);
    p = {m1_rvalid, m0_rvalid, m1_gnt, m0_gnt};
    check("pulse_count", $countones(p), 64'(p != 4'd0));
    for (int k = 0; k < 4; k++) begin
      if (p[k]) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", k, 99);
        end else begin
          ev = exp_q.pop_front();
          check("pulse_kind", k, {ev.is_rsp, ev.m1});
          check("pulse_cycle", cyc, ev.cyc);
          if (ev.is_rsp) begin
            check("rsp_rdata", rsp_rdata, ev.rdata);
            check("rsp_err", rsp_err, ev.err);
          end
        end
      end
    end
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      ev = exp_q.pop_front();
      check("missing_pulse", 0, {ev.is_rsp, ev.m1});
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  task automatic new_m0();
    m0_addr = {$urandom, $urandom};
    m0_size = 3'($urandom_range(0, 7));
  endtask

  task automatic new_m1();
    m1_wen   = 1'($urandom_range(0, 1));
    m1_addr  = {$urandom, $urandom};
    m1_size  = 3'($urandom_range(0, 7));
    m1_wdata = {$urandom, $urandom};
    m1_wmask = 8'($urandom);
  endtask

  // Phases: 0 random ready, 1 both requests held + ready always, 2 no ready (timeouts),
  // 3 random ready with occasional resets.
  task automatic drive_step(input int c);
    int  phase;
    bit  hold;
    phase = (c / 500) % 4;
    hold  = (phase == 1);
    rst_n = (phase == 3) ? ($urandom_range(0, 59) != 0) : 1'b1;
    if (m0_gnt) begin
      m0_req = hold || ($urandom_range(0, 1) == 1);
      new_m0();
    end else if (!m0_req && (hold || $urandom_range(0, 2) == 0)) begin
      m0_req = 1'b1;
      new_m0();
    end
    if (m1_gnt) begin
      m1_req = hold || ($urandom_range(0, 1) == 1);
      new_m1();
    end else if (!m1_req && (hold || $urandom_range(0, 2) == 0)) begin
      m1_req = 1'b1;
      new_m1();
    end
    case (phase)
      1:       s_ready = 1'b1;
      2:       s_ready = 1'b0;
      3:       s_ready = ($urandom_range(0, 99) < 25);
      default: s_ready = ($urandom_range(0, 99) < 40);
    endcase
    s_rdata = {$urandom, $urandom};
  endtask

  initial begin
    rst_n = 1'b0; s_ready = 1'b0; s_rdata = '0;
    m0_req = 1'b0; m0_addr = '0; m0_size = '0;
    m1_req = 1'b0; m1_wen = 1'b0; m1_addr = '0; m1_size = '0; m1_wdata = '0; m1_wmask = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < N_CYC; c++) begin
      @(posedge clk);
      #1;
      drive_step(c);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1; m0_req = 1'b0; m1_req = 1'b0; s_ready = 1'b0;
    repeat (int'(TO) + 4) @(posedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("timeout_seen", 64'(n_timeout > 0), 1);
    check("grants_seen", 64'(n_grant > 20), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
